aq_djpeg_pixout: RTL and testbench

Parametrised pixel output stage placed between the YCbCr-to-RGB converter and the decoder's external pixel port. It replaces the fixed "pixel inside image" gating with:
- a programmable crop window,
- selectable output format (RGB888, RGB565 or Gray8),
- a FIFO of configurable depth with a ready/valid handshake,
- frame-completion detection.

Pixels may arrive in any order, including MCU block order. Coordinates travel with each pixel, so no raster reordering is done here.

---
 rtl/aq_djpeg_pixout.sv | 212 +++++++++++++++++++++
 tb/tb_aq_djpeg_pixout.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_pixout.sv
// rtl/aq_djpeg_pixout.sv - pixel output stage: crop window, format conversion, output FIFO, frame completion
//
// Purpose: takes RGB pixels (with their own coordinates, any arrival order) from the
// colour converter, drops pixels outside the crop window, converts the rest to
// RGB888 / RGB565 / Gray8 and queues them in a first-word fall-through FIFO
// towards the external pixel port. FrameDone pulses once the configured number
// of pixels has been popped.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   ProcessInit           synchronous clear while high (decoder idle)
//   CfgFormat             0 RGB888, 1 RGB565, 2 Gray8, 3 RGB888
//   CfgX0/CfgY0/CfgW/CfgH crop window origin and size
//   InEnable/InReady      input handshake
//   InPixelX/InPixelY     source coordinates
//   InR/InG/InB           input pixel
//   OutValid/OutReady     output handshake (FIFO head)
//   OutData/OutX/OutY     formatted pixel and cropped coordinates
//   FrameDone             one-cycle pulse after the last pixel of the frame pops
module aq_djpeg_pixout #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ProcessInit,
    input  logic [1:0]  CfgFormat,
    input  logic [15:0] CfgX0,
    input  logic [15:0] CfgY0,
    input  logic [15:0] CfgW,
    input  logic [15:0] CfgH,
    input  logic        InEnable,
    output logic        InReady,
    input  logic [15:0] InPixelX,
    input  logic [15:0] InPixelY,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [23:0] OutData,
    output logic [15:0] OutX,
    output logic [15:0] OutY,
    output logic        FrameDone
);

    localparam logic [AW+1:0] FILL_LIMIT = (AW+2)'(DEPTH - 1);

    // FIFO state
    logic [55:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   occ;
    logic [55:0]   head;

    // Stage 1: cropped coordinates, raw RGB and gray partial products
    logic          s1Valid;
    logic [15:0]   s1X;
    logic [15:0]   s1Y;
    logic [7:0]    s1R;
    logic [7:0]    s1G;
    logic [7:0]    s1B;
    logic [14:0]   s1Pr;
    logic [15:0]   s1Pg;
    logic [12:0]   s1Pb;

    // Stage 2: formatted pixel waiting to be written into the FIFO
    logic          s2Valid;
    logic [23:0]   s2Data;
    logic [15:0]   s2X;
    logic [15:0]   s2Y;

    // Frame counting
    logic [31:0]   targetCount;
    logic [31:0]   popCount;

    logic          accept;
    logic          inWindow;
    logic          pop;
    logic [16:0]   xEnd;
    logic [16:0]   yEnd;
    logic [15:0]   graySum;
    logic [23:0]   fmtData;
    logic [AW+1:0] fillLevel;

    // 17-bit window ends so that origin + size can never wrap.
    assign xEnd = {1'b0, CfgX0} + {1'b0, CfgW};
    assign yEnd = {1'b0, CfgY0} + {1'b0, CfgH};

    assign inWindow = ({1'b0, InPixelX} >= {1'b0, CfgX0}) && ({1'b0, InPixelX} < xEnd) &&
                      ({1'b0, InPixelY} >= {1'b0, CfgY0}) && ({1'b0, InPixelY} < yEnd);

    // Everything already committed downstream of the input is counted, so a
    // stage-2 write can never find the FIFO full.
    assign fillLevel = {1'b0, occ} + (AW+2)'(s1Valid) + (AW+2)'(s2Valid);
    assign InReady   = rst && !ProcessInit && (fillLevel <= FILL_LIMIT);
    assign accept    = InEnable && InReady;

    assign OutValid = (occ != '0);
    assign pop      = OutValid && OutReady;
    assign head     = mem[rdPtr];
    assign OutData  = OutValid ? head[55:32] : 24'd0;
    assign OutX     = OutValid ? head[31:16] : 16'd0;
    assign OutY     = OutValid ? head[15:0]  : 16'd0;

    // The gray weights sum to 256, so the rounded sum peaks at 65408 and fits 16 bits.
    assign graySum = 16'(s1Pr) + s1Pg + 16'(s1Pb) + 16'd128;

    always_comb begin
        fmtData = {s1R, s1G, s1B};
        case (CfgFormat)
            2'd1:    fmtData = {8'd0, s1R[7:3], s1G[7:2], s1B[7:3]};
            2'd2:    fmtData = {8'd0, graySum} >> 8;
            default: fmtData = {s1R, s1G, s1B};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Valid <= 1'b0;
            s1X     <= '0;
            s1Y     <= '0;
            s1R     <= '0;
            s1G     <= '0;
            s1B     <= '0;
            s1Pr    <= '0;
            s1Pg    <= '0;
            s1Pb    <= '0;
        end else if (ProcessInit) begin
            s1Valid <= 1'b0;
        end else begin
            s1Valid <= accept && inWindow;
            if (accept && inWindow) begin
                s1X  <= InPixelX - CfgX0;
                s1Y  <= InPixelY - CfgY0;
                s1R  <= InR;
                s1G  <= InG;
                s1B  <= InB;
                s1Pr <= 15'(InR) * 15'd77;
                s1Pg <= 16'(InG) * 16'd150;
                s1Pb <= 13'(InB) * 13'd29;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2Valid <= 1'b0;
            s2Data  <= '0;
            s2X     <= '0;
            s2Y     <= '0;
        end else if (ProcessInit) begin
            s2Valid <= 1'b0;
        end else begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Data <= fmtData;
                s2X    <= s1X;
                s2Y    <= s1Y;
            end
        end
    end

    // FIFO storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (s2Valid) begin
            mem[wrPtr] <= {s2Data, s2X, s2Y};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else if (ProcessInit) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (s2Valid) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({s2Valid, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            targetCount <= '0;
            popCount    <= '0;
            FrameDone   <= 1'b0;
        end else if (ProcessInit) begin
            targetCount <= 32'(CfgW) * 32'(CfgH);
            popCount    <= '0;
            FrameDone   <= 1'b0;
        end else begin
            FrameDone <= pop && ((popCount + 32'd1) == targetCount);
            if (pop) begin
                popCount <= popCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_pixout.sv
// tb/tb_aq_djpeg_pixout.sv - self-checking bench for aq_djpeg_pixout
module tb_aq_djpeg_pixout;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ProcessInit;
    logic [1:0]  CfgFormat;
    logic [15:0] CfgX0, CfgY0, CfgW, CfgH;
    logic        InEnable;
    logic        InReady;
    logic [15:0] InPixelX, InPixelY;
    logic [7:0]  InR, InG, InB;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] OutData;
    logic [15:0] OutX, OutY;
    logic        FrameDone;

    int          readyMode;
    logic        rndBit;

    int          nCompared;
    int          nMismatched;

    logic [55:0] expQ[$];
    longint      popCount;
    longint      target;
    bit          expFd;
    bit          nextFd;
    int          popsTest;
    int          fdCount;
    int          popsAtFd;
    bit          haveFirst;
    logic [55:0] firstHead;

    aq_djpeg_pixout #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .CfgFormat(CfgFormat),
        .CfgX0(CfgX0), .CfgY0(CfgY0), .CfgW(CfgW), .CfgH(CfgH),
        .InEnable(InEnable), .InReady(InReady), .InPixelX(InPixelX), .InPixelY(InPixelY),
        .InR(InR), .InG(InG), .InB(InB),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutX(OutX), .OutY(OutY), .FrameDone(FrameDone)
    );

    always #5 clk = ~clk;

    assign OutReady = (readyMode == 1) || ((readyMode == 2) && rndBit);

    initial begin
        rndBit = 1'b0;
        forever begin
            @(posedge clk);
            #1 rndBit = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] fmtPix(input int r, input int g, input int b, input int fmt);
        case (fmt)
            1:       return 24'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
            2:       return 24'((77 * r + 150 * g + 29 * b + 128) / 256);
            default: return 24'(r * 65536 + g * 256 + b);
        endcase
    endfunction

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin
        int x, y;
        expFd = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                expQ.delete();
                popCount = 0;
                expFd = 0;
            end else begin
                check("FrameDone", 64'(FrameDone), 64'(expFd));
                nextFd = 0;
                if (FrameDone) begin
                    fdCount++;
                    popsAtFd = popsTest;
                end
                if (OutValid) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_output", 64'({OutData, OutX, OutY}), 64'h0);
                    end else begin
                        check("head", 64'({OutData, OutX, OutY}), 64'(expQ[0]));
                        if (!haveFirst) begin
                            haveFirst = 1;
                            firstHead = {OutData, OutX, OutY};
                        end
                        if (OutReady && !ProcessInit) begin
                            void'(expQ.pop_front());
                            popCount++;
                            popsTest++;
                            if (popCount == target) nextFd = 1;
                        end
                    end
                end else begin
                    check("idle_outputs_zero", 64'({OutData, OutX, OutY}), 64'h0);
                end
                if (InEnable && InReady) begin
                    x = int'(InPixelX);
                    y = int'(InPixelY);
                    if (x >= int'(CfgX0) && x < int'(CfgX0) + int'(CfgW) &&
                        y >= int'(CfgY0) && y < int'(CfgY0) + int'(CfgH)) begin
                        expQ.push_back({fmtPix(int'(InR), int'(InG), int'(InB), int'(CfgFormat)),
                                        16'(x - int'(CfgX0)), 16'(y - int'(CfgY0))});
                    end
                end
                if (ProcessInit) begin
                    expQ.delete();
                    popCount  = 0;
                    popsTest  = 0;
                    fdCount   = 0;
                    popsAtFd  = -1;
                    haveFirst = 0;
                    target    = longint'(CfgW) * longint'(CfgH);
                    nextFd    = 0;
                end
                expFd = nextFd;
            end
        end
    end

    task automatic configure(input int fmt, input int x0, input int y0, input int w, input int h);
        @(posedge clk);
        #1;
        CfgFormat   = 2'(fmt);
        CfgX0       = 16'(x0);
        CfgY0       = 16'(y0);
        CfgW        = 16'(w);
        CfgH        = 16'(h);
        ProcessInit = 1'b1;
        @(posedge clk);
        #1 ProcessInit = 1'b0;
    endtask

    task automatic sendPix(input int x, input int y, input int r, input int g, input int b);
        bit acc;
        acc = 0;
        InPixelX = 16'(x);
        InPixelY = 16'(y);
        InR = 8'(r);
        InG = 8'(g);
        InB = 8'(b);
        InEnable = 1'b1;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clk);
            acc = InReady;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        InEnable = 1'b0;
    endtask

    task automatic waitValid();
        bit seen;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = OutValid;
        end
        if (!seen) check("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic popOne();
        @(posedge clk);
        #1 readyMode = 1;
        @(posedge clk);
        #1 readyMode = 0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        readyMode = 1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            done = (expQ.size() == 0) && !OutValid;
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        nCompared = 0;
        nMismatched = 0;
        readyMode = 0;
        rst = 1'b0;
        ProcessInit = 1'b0;
        CfgFormat = 2'd0;
        CfgX0 = 16'd0; CfgY0 = 16'd0; CfgW = 16'd0; CfgH = 16'd0;
        InEnable = 1'b0;
        InPixelX = 16'd0; InPixelY = 16'd0;
        InR = 8'd0; InG = 8'd0; InB = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_OutValid", 64'(OutValid), 64'd0);
        check("rst_InReady", 64'(InReady), 64'd0);
        check("rst_FrameDone", 64'(FrameDone), 64'd0);
        check("rst_OutData", 64'(OutData), 64'd0);
        check("rst_OutX", 64'(OutX), 64'd0);
        check("rst_OutY", 64'(OutY), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("InReady_after_reset", 64'(InReady), 64'd1);

        // RGB888 crop of a 32x32 image in MCU order
        configure(0, 8, 8, 16, 16);
        readyMode = 1;
        for (int by = 0; by < 4; by++)
            for (int bx = 0; bx < 4; bx++)
                for (int yy = 0; yy < 8; yy++)
                    for (int xx = 0; xx < 8; xx++)
                        sendPix(bx * 8 + xx, by * 8 + yy, bx * 8 + xx, by * 8 + yy, 8'h5A);
        drain();
        check("crop_pop_count", 64'(popsTest), 64'd256);
        check("crop_framedone_count", 64'(fdCount), 64'd1);
        check("crop_framedone_at_pop", 64'(popsAtFd), 64'd256);
        check("crop_first_head", 64'(firstHead), {8'h0, 24'h08085A, 16'd0, 16'd0});

        // Gray8
        configure(2, 0, 0, 16, 16);
        readyMode = 0;
        sendPix(0, 0, 255, 255, 255);
        waitValid();
        check("gray_white", 64'(OutData), 64'h0000FF);
        popOne();
        sendPix(1, 0, 100, 50, 200);
        waitValid();
        check("gray_mix", 64'(OutData), 64'h000052);
        popOne();
        drain();

        // RGB565
        configure(1, 0, 0, 16, 16);
        readyMode = 0;
        sendPix(0, 0, 8'hF8, 8'hFC, 8'hF8);
        waitValid();
        check("rgb565_max", 64'(OutData), 64'h00FFFF);
        popOne();
        sendPix(1, 0, 8'h12, 8'h34, 8'h56);
        waitValid();
        check("rgb565_mix", 64'(OutData), 64'h0011AA);
        popOne();
        drain();

        // Backpressure: four accepts fill the stage, then random release
        configure(0, 0, 0, 16, 16);
        readyMode = 0;
        acc = 0;
        InEnable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            InPixelX = 16'(acc);
            InPixelY = 16'd0;
            InR = 8'(acc); InG = 8'(acc * 3); InB = 8'(acc * 7);
            @(negedge clk);
            if (InReady) acc++;
            @(posedge clk);
            #1;
        end
        InEnable = 1'b0;
        check("bp_accepts", 64'(acc), 64'd4);
        @(negedge clk);
        check("bp_InReady_low", 64'(InReady), 64'd0);
        @(posedge clk);
        #1 readyMode = 2;
        for (int i = 0; i < 16; i++) sendPix(i, 1, i + 40, i + 80, i + 120);
        drain();
        check("bp_pop_count", 64'(popsTest), 64'd20);

        // Window at the top of the coordinate range
        configure(0, 16'hFFF0, 0, 16'h20, 1);
        sendPix(16'hFFEF, 0, 1, 2, 3);
        for (int x = 16'hFFF0; x <= 16'hFFFF; x++) sendPix(x, 0, x & 255, 8'h11, 8'h22);
        sendPix(16'hFFF5, 1, 4, 5, 6);
        drain();
        check("edge_pop_count", 64'(popsTest), 64'd16);
        check("edge_first_head", 64'(firstHead), {8'h0, 24'hF01122, 16'd0, 16'd0});
        check("edge_no_framedone", 64'(fdCount), 64'd0);

        // Zero-width window drops everything
        configure(0, 0, 0, 0, 4);
        for (int i = 0; i < 8; i++) sendPix(i & 3, i >> 2, i, i, i);
        drain();
        check("w0_pop_count", 64'(popsTest), 64'd0);
        check("w0_no_framedone", 64'(fdCount), 64'd0);

        // ProcessInit mid-frame, then a clean 4x4 frame
        configure(0, 0, 0, 4, 4);
        readyMode = 0;
        for (int i = 0; i < 3; i++) sendPix(i, 0, i, i, i);
        repeat (4) @(posedge clk);
        #1 ProcessInit = 1'b1;
        @(posedge clk);
        #1 ProcessInit = 1'b0;
        @(negedge clk);
        check("init_OutValid_cleared", 64'(OutValid), 64'd0);
        @(posedge clk);
        #1 readyMode = 1;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) sendPix(x, y, x * 16, y * 16, 8'h33);
        drain();
        check("init_pop_count", 64'(popsTest), 64'd16);
        check("init_framedone_count", 64'(fdCount), 64'd1);
        check("init_framedone_at_pop", 64'(popsAtFd), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
